// File: rtl/score_reader.sv
// Walks the score register file (count at address 0, scores at 1..N) and produces
// best, worst and average scores. Optional build macro: SCORE_READER_ROUND_EN (round-half-up average).
module score_reader #(
    parameter int unsigned DATA_WIDTH  = 13,
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned MAX_ENTRIES = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [DATA_WIDTH-1:0] ReadData,
    output logic [ADDR_WIDTH-1:0] ReadAddress,
    output logic                  Busy,
    output logic                  Done,
    output logic                  ResultValid,
    output logic                  Empty,
    output logic [DATA_WIDTH-1:0] BestScore,
    output logic [DATA_WIDTH-1:0] WorstScore,
    output logic [DATA_WIDTH-1:0] AverageScore,
    output logic [2:0]            State
);

    localparam int unsigned SUM_W = DATA_WIDTH + ADDR_WIDTH;
    localparam int unsigned CNT_W = $clog2(SUM_W);
    localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(MAX_ENTRIES);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SUM_W - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'b000,
        S_READ_COUNT = 3'b001,
        S_READ_SCORE = 3'b010,
        S_DIVIDE     = 3'b011,
        S_DONE       = 3'b100
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] n_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH-1:0] rem_q;
    logic [SUM_W-1:0]      sum_q;
    logic [SUM_W-1:0]      quo_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] best_acc_q;
    logic [DATA_WIDTH-1:0] worst_acc_q;
    logic [DATA_WIDTH-1:0] best_q;
    logic [DATA_WIDTH-1:0] worst_q;
    logic [DATA_WIDTH-1:0] avg_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  valid_q;
    logic                  empty_q;

    logic [ADDR_WIDTH-1:0] count_d;
    logic [SUM_W-1:0]      sum_d;
    logic [SUM_W-1:0]      dividend_d;
    logic [ADDR_WIDTH:0]   rem_shift_d;
    logic [ADDR_WIDTH:0]   rem_sub_d;
    logic                  rem_fits_d;

    // Clamp compares the full data word so large stored counts never alias to small ones.
    assign count_d = (ReadData > DATA_WIDTH'(MAX_ENTRIES)) ? MAX_N : ReadData[ADDR_WIDTH-1:0];
    assign sum_d   = sum_q + SUM_W'(ReadData);

`ifdef SCORE_READER_ROUND_EN
    assign dividend_d = sum_d + SUM_W'(n_q >> 1);
`else
    assign dividend_d = sum_d;
`endif

    // Restoring divide step: quo_q shifts the dividend out at the top and the quotient in at the bottom.
    assign rem_shift_d = {rem_q, quo_q[SUM_W-1]};
    assign rem_fits_d  = (rem_shift_d >= {1'b0, n_q});
    assign rem_sub_d   = rem_shift_d - {1'b0, n_q};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            rem_q       <= '0;
            sum_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            best_acc_q  <= '0;
            worst_acc_q <= '0;
            best_q      <= '0;
            worst_q     <= '0;
            avg_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            empty_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    idx_q <= '0;
                    if (Start) begin
                        state_q     <= S_READ_COUNT;
                        busy_q      <= 1'b1;
                        valid_q     <= 1'b0;
                        empty_q     <= 1'b0;
                        sum_q       <= '0;
                        best_acc_q  <= '1;
                        worst_acc_q <= '0;
                    end
                end
                S_READ_COUNT: begin
                    n_q <= count_d;
                    if (count_d == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_READ_SCORE;
                        idx_q   <= ADDR_WIDTH'(1);
                    end
                end
                S_READ_SCORE: begin
                    sum_q <= sum_d;
                    if (ReadData < best_acc_q) begin
                        best_acc_q <= ReadData;
                    end
                    if (ReadData > worst_acc_q) begin
                        worst_acc_q <= ReadData;
                    end
                    if (idx_q == n_q) begin
                        state_q <= S_DIVIDE;
                        idx_q   <= '0;
                        quo_q   <= dividend_d;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        idx_q <= idx_q + ADDR_WIDTH'(1);
                    end
                end
                S_DIVIDE: begin
                    if (rem_fits_d) begin
                        rem_q <= rem_sub_d[ADDR_WIDTH-1:0];
                        quo_q <= {quo_q[SUM_W-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_shift_d[ADDR_WIDTH-1:0];
                        quo_q <= {quo_q[SUM_W-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    valid_q <= 1'b1;
                    if (n_q == '0) begin
                        empty_q <= 1'b1;
                        best_q  <= '0;
                        worst_q <= '0;
                        avg_q   <= '0;
                    end else begin
                        empty_q <= 1'b0;
                        best_q  <= best_acc_q;
                        worst_q <= worst_acc_q;
                        avg_q   <= quo_q[DATA_WIDTH-1:0];
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign ReadAddress  = idx_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign ResultValid  = valid_q;
    assign Empty        = empty_q;
    assign BestScore    = best_q;
    assign WorstScore   = worst_q;
    assign AverageScore = avg_q;
    assign State        = state_q;

endmodule

// File: tb/tb_score_reader.sv
// Self-checking bench for score_reader: directed vector table, multi-cycle corner
// sequences and randomized runs against an arithmetic reference model.
module tb_score_reader;

    localparam int unsigned DW   = 13;
    localparam int unsigned AW   = 3;
    localparam int unsigned MAXN = 4;
`ifdef SCORE_READER_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [DW-1:0] ReadData;
    logic [AW-1:0] ReadAddress;
    logic          Busy, Done, ResultValid, Empty;
    logic [DW-1:0] BestScore, WorstScore, AverageScore;
    logic [2:0]    State;

    logic [DW-1:0] mem [8];
    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;
    assign ReadData = mem[ReadAddress];

    score_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_ENTRIES(MAXN)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .ReadData(ReadData),
        .ReadAddress(ReadAddress), .Busy(Busy), .Done(Done), .ResultValid(ResultValid),
        .Empty(Empty), .BestScore(BestScore), .WorstScore(WorstScore),
        .AverageScore(AverageScore), .State(State)
    );

    typedef struct {
        logic [DW-1:0] cnt, s1, s2, s3, s4, s5, s6;
        logic [DW-1:0] best, worst, avg_t, avg_r;
        logic          empty;
        int            lat;
        int            addr;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    // Reference: results straight from the stored entries with integer arithmetic.
    function automatic void model(output logic [DW-1:0] b, output logic [DW-1:0] w,
                                  output logic [DW-1:0] a, output logic e,
                                  output int lat, output int addr);
        int n;
        int sum;
        int mn;
        int mx;
        n   = (int'(mem[0]) > int'(MAXN)) ? int'(MAXN) : int'(mem[0]);
        sum = 0;
        mn  = 8191;
        mx  = 0;
        for (int i = 1; i <= n; i++) begin
            sum += int'(mem[i]);
            if (int'(mem[i]) < mn) mn = int'(mem[i]);
            if (int'(mem[i]) > mx) mx = int'(mem[i]);
        end
        if (n == 0) begin
            b = '0; w = '0; a = '0; e = 1'b1; lat = 2; addr = 0;
        end else begin
            b    = DW'(mn);
            w    = DW'(mx);
            a    = DW'((sum + (ROUND ? n / 2 : 0)) / n);
            e    = 1'b0;
            lat  = n + 18;
            addr = n;
        end
    endfunction

    task automatic run_check(input string tag, input logic [DW-1:0] eb, input logic [DW-1:0] ew,
                             input logic [DW-1:0] ea, input logic ee, input int elat, input int eaddr);
        int lat;
        int max_addr;
        cyc();
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        check({tag, "_busy_at_start"}, 32'(Busy), 32'd1);
        check({tag, "_valid_cleared"}, 32'(ResultValid), 32'd0);
        check({tag, "_state_read_count"}, 32'(State), 32'd1);
        lat = 0;
        max_addr = int'(ReadAddress);
        while (!Done && lat < 200) begin
            cyc();
            lat++;
            if (int'(ReadAddress) > max_addr) max_addr = int'(ReadAddress);
        end
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_max_addr"}, 32'(max_addr), 32'(eaddr));
        check({tag, "_best"}, 32'(BestScore), 32'(eb));
        check({tag, "_worst"}, 32'(WorstScore), 32'(ew));
        check({tag, "_avg"}, 32'(AverageScore), 32'(ea));
        check({tag, "_empty"}, 32'(Empty), 32'(ee));
        check({tag, "_valid"}, 32'(ResultValid), 32'd1);
        cyc();
        check({tag, "_done_pulse"}, 32'(Done), 32'd0);
        check({tag, "_valid_holds"}, 32'(ResultValid), 32'd1);
        check({tag, "_idle"}, 32'(Busy), 32'd0);
    endtask

    task automatic load_vec(input vec_t v);
        mem[0] = v.cnt; mem[1] = v.s1; mem[2] = v.s2; mem[3] = v.s3;
        mem[4] = v.s4;  mem[5] = v.s5; mem[6] = v.s6; mem[7] = 13'd4321;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, 32'(ReadAddress), 32'd0);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_done"}, 32'(Done), 32'd0);
        check({tag, "_valid"}, 32'(ResultValid), 32'd0);
        check({tag, "_empty"}, 32'(Empty), 32'd0);
        check({tag, "_best"}, 32'(BestScore), 32'd0);
        check({tag, "_worst"}, 32'(WorstScore), 32'd0);
        check({tag, "_avg"}, 32'(AverageScore), 32'd0);
        check({tag, "_state"}, 32'(State), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] b, w, a;
        logic          e;
        int            lat, addr, ndone, first;

        for (int i = 0; i < 8; i++) mem[i] = '0;
        //            cnt   s1    s2    s3    s4    s5  s6   best  worst avg_t avg_r emp lat addr
        vecs[0] = '{4,    100,  200,  300,  400,  0,  0,   100,  400,  250,  250,  0, 22, 4};
        vecs[1] = '{0,    9,    9,    9,    9,    9,  9,   0,    0,    0,    0,    1, 2,  0};
        vecs[2] = '{6,    10,   20,   30,   40,   5,  5,   10,   40,   25,   25,   0, 22, 4};
        vecs[3] = '{2,    1,    2,    0,    0,    0,  0,   1,    2,    1,    2,    0, 20, 2};
        vecs[4] = '{2,    8191, 8191, 0,    0,    0,  0,   8191, 8191, 8191, 8191, 0, 20, 2};
        vecs[5] = '{1,    7,    0,    0,    0,    0,  0,   7,    7,    7,    7,    0, 19, 1};
        vecs[6] = '{8191, 3,    9,    6,    0,    1,  1,   0,    9,    4,    5,    0, 22, 4};
        vecs[7] = '{3,    5,    6,    6,    0,    0,  0,   5,    6,    5,    6,    0, 21, 3};
        vecs[8] = '{4,    8191, 8191, 8191, 8191, 0,  0,   8191, 8191, 8191, 8191, 0, 22, 4};
        vecs[9] = '{8,    1,    1,    1,    2,    0,  0,   1,    2,    1,    1,    0, 22, 4};

        repeat (2) @(posedge Clock);
        #1;
        check_all_zero("reset");
        @(negedge Clock);
        Reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            load_vec(vecs[i]);
            run_check($sformatf("vec%0d", i), vecs[i].best, vecs[i].worst,
                      ROUND ? vecs[i].avg_r : vecs[i].avg_t, vecs[i].empty,
                      vecs[i].lat, vecs[i].addr);
        end

        // Start pulsed mid-divide must be ignored: one Done only.
        load_vec(vecs[0]);
        cyc();
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        ndone = 0;
        first = -1;
        for (int c = 1; c <= 60; c++) begin
            Start = (c == 10);
            cyc();
            if (Done) begin
                ndone++;
                if (first < 0) first = c;
            end
        end
        Start = 1'b0;
        check("ignore_start_done_count", 32'(ndone), 32'd1);
        check("ignore_start_latency", 32'(first), 32'd22);

        // Start held high: re-trigger on the IDLE cycle right after DONE.
        cyc();
        Start = 1'b1;
        cyc();
        lat = 0;
        while (!Done && lat < 200) begin cyc(); lat++; end
        check("held_first_latency", 32'(lat), 32'd22);
        cyc();
        check("held_retrigger_busy", 32'(Busy), 32'd1);
        check("held_retrigger_valid", 32'(ResultValid), 32'd0);
        lat = 0;
        while (!Done && lat < 200) begin cyc(); lat++; end
        Start = 1'b0;
        check("held_second_latency", 32'(lat), 32'd22);
        check("held_second_avg", 32'(AverageScore), 32'd250);
        repeat (3) cyc();
        check("held_released_idle", 32'(Busy), 32'd0);

        // Async reset in the middle of READ_SCORE.
        cyc();
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        cyc();
        cyc();
        check("pre_reset_state", 32'(State), 32'd2);
        #2;
        Reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge Clock);
        Reset = 1'b0;
        run_check("post_reset", vecs[0].best, vecs[0].worst,
                  ROUND ? vecs[0].avg_r : vecs[0].avg_t, 1'b0, 22, 4);

        // Randomized contents against the reference model.
        for (int r = 0; r < 40; r++) begin
            mem[0] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 7));
            for (int k = 1; k < 8; k++) begin
                mem[k] = ($urandom_range(0, 1) == 0) ? DW'($urandom) : DW'($urandom_range(0, 50));
            end
            model(b, w, a, e, lat, addr);
            run_check($sformatf("rand%0d", r), b, w, a, e, lat, addr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_reader.md
Name: score_reader

Overview:
Read-side companion to the reaction-time game controller, which writes scores into the 8x13 register file. On request, walks the stored entries through a read port and produces best (minimum), worst (maximum) and average reaction scores for display. Address 0 holds the entry count N; scores live at addresses 1..N. Uses a multi-cycle restoring divider for the average, so results are ready a fixed number of cycles after Start.

Parameters:
DATA_WIDTH, 13, width of one score and of register-file data
ADDR_WIDTH, 3, register-file address width
MAX_ENTRIES, 4, max scores read; a larger stored count is clamped to this (must be 1..2^ADDR_WIDTH-1)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  request a summary; sampled only in IDLE
ReadData  input  DATA_WIDTH  register-file read data, combinational from ReadAddress
ReadAddress  output  ADDR_WIDTH  register-file read address
Busy  output  1  high in every state except IDLE
Done  output  1  one-cycle pulse when results update
ResultValid  output  1  level; high from Done until next accepted Start or Reset
Empty  output  1  valid with ResultValid; count read as 0
BestScore  output  DATA_WIDTH  minimum score read
WorstScore  output  DATA_WIDTH  maximum score read
AverageScore  output  DATA_WIDTH  sum / N, truncated (see optional feature)
State  output  3  current state encoding, for debug LEDs

Behaviour:
- Reset (async, any state): state IDLE; ReadAddress=0; Busy, Done, ResultValid, Empty=0; BestScore, WorstScore, AverageScore=0; sum, index and divider registers cleared.
- States/encoding: IDLE=000, READ_COUNT=001, READ_SCORE=010, DIVIDE=011, DONE=100; 101-111 return to IDLE next cycle.
- IDLE: ReadAddress=0. Start=1 -> READ_COUNT; clear ResultValid, Empty and the accumulators. Best is preset to all-ones, Worst to 0, and sum to 0.
- READ_COUNT, 1 cycle: ReadAddress=0. Latch N = min(ReadData, MAX_ENTRIES). Upper ReadData bits are considered when clamping.
  - N==0 -> DONE with Empty=1 and all three results 0.
  - Otherwise -> READ_SCORE with index=1.
- READ_SCORE, one cycle per entry: ReadAddress=index. Each cycle:
  - sum += ReadData. sum is DATA_WIDTH+ADDR_WIDTH bits (16) and cannot overflow.
  - Best = min(Best, ReadData); Worst = max(Worst, ReadData), both unsigned.
  - index==N -> DIVIDE; else index++.
- DIVIDE: restoring divide of sum by N, one quotient bit per cycle, MSB first. Runs exactly DATA_WIDTH+ADDR_WIDTH cycles (16), then -> DONE. Quotient is truncated to DATA_WIDTH bits, which is lossless since quotient <= max score.
- DONE, 1 cycle: Done=1; register AverageScore, BestScore, WorstScore, Empty; set ResultValid; -> IDLE.
- Result registers are written only in DONE. Between Start and Done they hold the previous values while ResultValid=0.
- Latency from Start sampled high in IDLE to the Done pulse:
  - N>0: 1 + N + 16 + 1 cycles (22 for N=4).
  - N==0: 2 cycles.
- Start while Busy is ignored and not queued. Start held high re-triggers on the first IDLE cycle after DONE.
- ReadData is sampled only in READ_COUNT/READ_SCORE; it is don't-care in other states.

Optional Feature:
SCORE_READER_ROUND_EN
- Defined: DIVIDE computes (sum + floor(N/2)) / N, i.e. round-half-up, using the same cycle count.
- Undefined: truncating sum / N.
- All other behaviour and timing are identical in both builds.

Test Plan:
- Mem[0]=4, Mem[1..4]=100,200,300,400; pulse Start -> Done 22 cycles later; Best=100, Worst=400, Average=250, Empty=0, ResultValid stays 1.
- Mem[0]=0; Start -> Done 2 cycles later; Empty=1, Best=Worst=Average=0; ReadAddress never leaves 0.
- Mem[0]=6, MAX_ENTRIES=4, Mem[1..6]=10,20,30,40,5,5 -> only addresses 1..4 read; Best=10, Worst=40, Average=25.
- Mem[0]=2, Mem[1..2]=1,2 -> Average=1 without SCORE_READER_ROUND_EN, Average=2 with it; Mem[1..2]=8191,8191 -> Average=8191 in both builds.
- Start pulsed again during DIVIDE -> ignored, single Done; Start held high -> new run begins the cycle after DONE, ResultValid drops.
- Assert Reset mid-READ_SCORE -> all outputs 0 immediately (async); after release, a fresh Start runs the full sequence correctly.
